// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser: FSM states, error
// codes, default sync marker and the modulo-256 checksum helper.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_SYNC    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE = 2'd0;
  localparam err_code_t ERR_CHK  = 2'd1;
  localparam err_code_t ERR_LEN  = 2'd2;
  localparam err_code_t ERR_TO   = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hAA;

  // Checksum accumulation deliberately wraps at 8 bits.
  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte-in / frame-out bundle between the UART receiver side (master) and the
// frame parser (slave).
interface uart_frame_parser_if #(
  parameter int unsigned MAX_PAYLOAD = 8
);
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic [MAX_PAYLOAD*8-1:0] payload;
  logic [7:0]               payload_len;
  logic                     frame_ok;
  logic                     frame_err;
  logic [1:0]               err_code;
  logic                     busy;

  modport master (
    output rx_data, rx_valid,
    input  payload, payload_len, frame_ok, frame_err, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid,
    output payload, payload_len, frame_ok, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_byte_timer.sv
// Inter-byte silence counter; expire pulses for one cycle when the count
// reaches TO_CYC-1 while running and not being cleared.
module uart_byte_timer #(
  parameter int unsigned TO_CYC = 200
) (
  input  logic clk,
  input  logic res,
  input  logic clear,
  input  logic run,
  output logic expire
);
  localparam int unsigned CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A byte arriving on the expiry cycle suppresses the pulse.
  assign expire = run && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || !run || expire) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_frame_parser.sv
// Sync-hunting, length-prefixed frame parser with an 8-bit additive checksum
// and an inter-byte timeout; publishes the last good payload as a flat vector.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned CLK           = 50,
  parameter int unsigned BAUD_RATE     = 9600,
  parameter int unsigned MAX_PAYLOAD   = 8,
  parameter logic [7:0]  SYNC_BYTE     = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_BYTES = 4
) (
  input logic               clk,
  input logic               res,
  uart_frame_parser_if.slave bus
);
  localparam int unsigned TO_CYC = 32'(64'(TIMEOUT_BYTES) * 64'd10 * 64'(CLK) * 64'd1000000
                                       / 64'(BAUD_RATE));
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] payload_len_q, payload_len_d;
  logic       frame_ok_q, frame_ok_d;
  logic       frame_err_q, frame_err_d;
  err_code_t  err_code_q, err_code_d;
  logic       shadow_clr, shadow_wr, commit;
  logic       expire;
  logic       rx_valid;
  logic [7:0] rx_data;

  assign rx_valid = bus.rx_valid;
  assign rx_data  = bus.rx_data;

  uart_byte_timer #(
    .TO_CYC(TO_CYC)
  ) u_timer (
    .clk   (clk),
    .res   (res),
    .clear (rx_valid),
    .run   (state_q != S_SYNC),
    .expire(expire)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= S_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      case (state_q)
        S_SYNC: begin
          if (rx_data == SYNC_BYTE) state_d = S_LEN;
        end
        S_LEN: begin
          if (rx_data > MAX_LEN)      state_d = S_SYNC;
          else if (rx_data == 8'd0)   state_d = S_CHECK;
          else                        state_d = S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (idx_q == len_q - 8'd1) state_d = S_CHECK;
        end
        S_CHECK: state_d = S_SYNC;
        default: state_d = S_SYNC;
      endcase
    end else if (expire) begin
      state_d = S_SYNC;
    end
  end

  always_comb begin
    len_d         = len_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    payload_len_d = payload_len_q;
    err_code_d    = err_code_q;
    frame_ok_d    = 1'b0;
    frame_err_d   = 1'b0;
    shadow_clr    = 1'b0;
    shadow_wr     = 1'b0;
    commit        = 1'b0;
    if (rx_valid) begin
      case (state_q)
        S_LEN: begin
          if (rx_data > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else begin
            len_d      = rx_data;
            acc_d      = rx_data;
            idx_d      = '0;
            shadow_clr = 1'b1;
          end
        end
        S_PAYLOAD: begin
          shadow_wr = 1'b1;
          acc_d     = sum8(acc_q, rx_data);
          idx_d     = idx_q + 8'd1;
        end
        S_CHECK: begin
          if (sum8(acc_q, rx_data) == 8'd0) begin
            commit        = 1'b1;
            payload_len_d = len_q;
            frame_ok_d    = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end
        end
        default: ;
      endcase
    end else if (expire) begin
      frame_err_d = 1'b1;
      err_code_d  = ERR_TO;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      len_q         <= '0;
      acc_q         <= '0;
      idx_q         <= '0;
      payload_len_q <= '0;
      frame_ok_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      len_q         <= len_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      payload_len_q <= payload_len_d;
      frame_ok_q    <= frame_ok_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
    end
  end

  // Shadow bytes collect the frame in flight; payload bytes only move on commit,
  // so aborted frames never reach the published vector.
  genvar gi;
  for (gi = 0; gi < MAX_PAYLOAD; gi++) begin : g_byte
    logic [7:0] shadow_q, shadow_d;
    logic [7:0] payload_q, payload_d;

    always_comb begin
      shadow_d = shadow_q;
      if (shadow_clr) begin
        shadow_d = '0;
      end else if (shadow_wr && (idx_q == 8'(gi))) begin
        shadow_d = rx_data;
      end
      payload_d = commit ? shadow_q : payload_q;
    end

    always_ff @(posedge clk) begin
      if (res) begin
        shadow_q  <= '0;
        payload_q <= '0;
      end else begin
        shadow_q  <= shadow_d;
        payload_q <= payload_d;
      end
    end

    assign bus.payload[8*gi +: 8] = payload_q;
  end

  assign bus.payload_len = payload_len_q;
  assign bus.frame_ok    = frame_ok_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.err_code    = err_code_q;
  assign bus.busy        = (state_q != S_SYNC);
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed plus randomized bench for uart_frame_parser against a frame-level
// reference model built from byte queues.
module tb_uart_frame_parser;
  localparam int MAXP = 8;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  uart_frame_parser_if #(.MAX_PAYLOAD(MAXP)) bus ();

  uart_frame_parser #(
    .CLK          (1),
    .BAUD_RATE    (200000),
    .MAX_PAYLOAD  (MAXP),
    .SYNC_BYTE    (8'hAA),
    .TIMEOUT_BYTES(4)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: hunting flag plus the bytes seen since the sync marker.
  bit           m_hunt = 1'b1;
  byte unsigned m_frm[$];
  logic [63:0]  m_payload = '0;
  logic [7:0]   m_len = '0;
  logic [1:0]   m_code = '0;
  logic         m_ok = 1'b0;
  logic         m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hunt = 1'b1;
    m_frm.delete();
    m_payload = '0;
    m_len = '0;
    m_code = '0;
    m_ok = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int unsigned total;
    m_ok  = 1'b0;
    m_err = 1'b0;
    if (m_hunt) begin
      if (b == 8'hAA) begin
        m_hunt = 1'b0;
        m_frm.delete();
      end
    end else begin
      m_frm.push_back(b);
      if (m_frm.size() == 1 && int'(m_frm[0]) > MAXP) begin
        m_err = 1'b1; m_code = 2'd2; m_hunt = 1'b1;
      end else if (m_frm.size() == int'(m_frm[0]) + 2) begin
        total = 0;
        foreach (m_frm[i]) total += m_frm[i];
        if (total % 256 == 0) begin
          m_ok = 1'b1;
          m_len = m_frm[0];
          m_payload = '0;
          for (int i = 0; i < int'(m_len); i++) m_payload[8*i +: 8] = m_frm[i+1];
        end else begin
          m_err = 1'b1; m_code = 2'd1;
        end
        m_hunt = 1'b1;
      end
    end
  endtask

  task automatic model_timeout();
    m_ok = 1'b0;
    m_err = 1'b0;
    if (!m_hunt) begin
      m_err = 1'b1; m_code = 2'd3; m_hunt = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " frame_ok"},    64'(bus.frame_ok),    64'(m_ok));
    check({tag, " frame_err"},   64'(bus.frame_err),   64'(m_err));
    check({tag, " err_code"},    64'(bus.err_code),    64'(m_code));
    check({tag, " payload"},     bus.payload,          m_payload);
    check({tag, " payload_len"}, 64'(bus.payload_len), 64'(m_len));
    check({tag, " busy"},        64'(bus.busy),        64'(!m_hunt));
  endtask

  // Strobe one byte; consecutive calls give back-to-back rx_valid cycles.
  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    model_byte(b);
    check_outputs($sformatf("byte %02h", b));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    m_ok  = 1'b0;
    m_err = 1'b0;
    check_outputs("idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned len, junk, gap;
    logic [7:0]  b, sum, chk;

    res = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    res = 1'b0;
    model_reset();
    check_outputs("reset");

    // 1: junk, then a two-byte frame
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    check("t1 payload", bus.payload, 64'h0000_0000_0000_2211);
    check("t1 len", 64'(bus.payload_len), 64'd2);
    $display("t1 two-byte frame done");
    idle(2);

    // 2: empty frame, then a bad checksum that must not disturb payload
    send_byte(8'hAA); send_byte(8'h00); send_byte(8'h00);
    check("t2 ok", 64'(bus.frame_ok), 64'd1);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h55); send_byte(8'h00);
    check("t2 code", 64'(bus.err_code), 64'd1);
    check("t2 len held", 64'(bus.payload_len), 64'd0);
    $display("t2 empty frame and checksum error done");
    idle(1);

    // 3: length error, then a sync value used as payload data
    send_byte(8'hAA); send_byte(8'h09);
    check("t3 code", 64'(bus.err_code), 64'd2);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'hAA); send_byte(8'h55);
    check("t3 payload", bus.payload, 64'h0000_0000_0000_00AA);
    $display("t3 length error and in-payload sync done");
    idle(1);

    // 4: silence timeout; error appears on the edge 200 cycles after the strobe
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    repeat (199) @(negedge clk);
    check("t4 before expiry", 64'(bus.frame_err), 64'd0);
    @(negedge clk);
    model_timeout();
    check_outputs("t4 timeout");
    check("t4 code", 64'(bus.err_code), 64'd3);
    $display("t4 timeout done");
    idle(1);

    // 4b: a byte on the expiry cycle wins
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    repeat (199) @(negedge clk);
    send_byte(8'h22); send_byte(8'hCB);
    check("t4b ok", 64'(bus.frame_ok), 64'd1);
    $display("t4b byte on expiry cycle done");
    idle(1);

    // 5: reset mid-frame drops the frame silently
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    model_reset();
    check_outputs("t5 reset");
    send_byte(8'h22); send_byte(8'hCB);
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    $display("t5 mid-frame reset done");

    // 6: two frames with no gap at all
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
    check("t6 payload", bus.payload, 64'h0000_0000_0000_007F);
    check("t6 len", 64'(bus.payload_len), 64'd1);
    $display("t6 back-to-back frames done");

    // Randomized frames: junk, lengths 0..9, occasionally corrupted checksum
    for (int f = 0; f < 40; f++) begin
      junk = $urandom_range(0, 2);
      for (int j = 0; j < int'(junk); j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA) b = 8'h00;
        send_byte(b);
      end
      len = $urandom_range(0, 9);
      send_byte(8'hAA);
      send_byte(8'(len));
      if (len <= MAXP) begin
        sum = 8'(len);
        for (int k = 0; k < int'(len); k++) begin
          b = 8'($urandom_range(0, 255));
          sum = sum + b;
          send_byte(b);
        end
        chk = 8'd0 - sum;
        if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
        send_byte(chk);
      end
      $display("frame %0d: len %0d ok=%0b err=%0b code=%0d", f, len, m_ok, m_err, m_code);
      gap = $urandom_range(0, 2);
      if (gap != 0) idle(int'(gap));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-stream framer directly downstream of the UART receiver. Consumes one received byte per `rx_valid` strobe, hunts for a sync byte, and collects a length-prefixed payload with a trailing 8-bit checksum. It presents the validated payload as a flat vector to the command logic and flags checksum, length and inter-byte-timeout errors.

## Interface
- `CLK`, 50: system clock in MHz, used for the timeout calculation.
- `BAUD_RATE`, 9600: line baud rate, used for the timeout calculation.
- `MAX_PAYLOAD`, 8: maximum payload bytes, range 1–255.
- `SYNC_BYTE`, 8'hAA: frame start marker.
- `TIMEOUT_BYTES`, 4: silence limit in byte-times. The limit in cycles is `TO_CYC = TIMEOUT_BYTES*10*CLK*1000000/BAUD_RATE`.

Ports:
- `clk`  in  1: the single clock. All logic is on the rising edge.
- `res`  in  1: reset, synchronous and active-high.
- `rx_data`  in  8: received byte. Valid only while `rx_valid` is high.
- `rx_valid`  in  1: one-cycle strobe, one per received byte.
- `payload`  out  MAX_PAYLOAD*8: last good payload. Byte i is at `[8i+7:8i]`; the first received byte is at `[7:0]`. Bytes at or beyond `payload_len` are zero.
- `payload_len`  out  8: length of the last good frame.
- `frame_ok`  out  1: one-cycle pulse when a frame passes its checks.
- `frame_err`  out  1: one-cycle pulse when a frame is aborted.
- `err_code`  out  2: 1 = checksum, 2 = length, 3 = timeout. Valid while `frame_err` is high; holds its value otherwise.
- `busy`  out  1: high whenever the state is not S_SYNC.

## Operation
- Frame format: `SYNC_BYTE`, `LEN`, `LEN` payload bytes, `CHK`.
- A frame is good when (LEN + Σpayload + CHK) mod 256 == 0. The sum is an 8-bit accumulator that wraps modulo 256.

State machine (state advances only on `rx_valid`, except for timeout):
- **S_SYNC**:
  - A byte equal to `SYNC_BYTE` moves to S_LEN.
  - Any other byte is discarded silently, with no error.
- **S_LEN**:
  - LEN > MAX_PAYLOAD: pulse `frame_err` with code 2, return to S_SYNC.
  - LEN == 0: move to S_CHECK.
  - Otherwise: move to S_PAYLOAD.
  - For every accepted LEN: latch LEN, set the accumulator to LEN, clear the shadow buffer to zero, clear the byte index.
- **S_PAYLOAD**:
  - Write the byte into the shadow buffer at the current index, add it to the accumulator, increment the index.
  - After byte LEN−1, move to S_CHECK.
  - A byte equal to `SYNC_BYTE` is ordinary data here; there is no resync mid-frame.
- **S_CHECK**:
  - Pass: copy the shadow buffer to `payload`, copy LEN to `payload_len`, pulse `frame_ok`.
  - Fail: pulse `frame_err` with code 1; `payload` and `payload_len` are unchanged.
  - In either case, return to S_SYNC.

Timeout:
- The silence counter clears on every `rx_valid` and on entry to S_SYNC, and counts in every state except S_SYNC.
- When the counter reaches `TO_CYC−1` with no `rx_valid` that cycle: pulse `frame_err` with code 3 and return to S_SYNC.
- If `rx_valid` and expiry coincide, the byte wins: it is processed normally and the counter clears.

Outputs:
- `payload` and `payload_len` change only on `frame_ok`.
- Aborted frames never disturb them.

## Timing
- Reset values: state S_SYNC; `payload` = 0; `payload_len` = 0; `frame_ok` = 0; `frame_err` = 0; `err_code` = 0; `busy` = 0; counter, index and accumulator = 0.
- Reset mid-frame drops the partial frame with no error pulse.
- Latency from the `rx_valid` of the CHK byte:
  - `frame_ok` or `frame_err` is high in the next cycle, for exactly one cycle.
  - `payload` is updated on that same edge.
- A length error is flagged the cycle after the LEN byte's `rx_valid`.
- Back-to-back strobes, i.e. `rx_valid` on consecutive cycles, must be handled. A SYNC byte arriving in the same cycle as `frame_ok` or `frame_err` is high (the cycle after CHK) starts the next frame.
- `frame_ok` and `frame_err` are never high together.

## Structure
- Package `uart_frame_pkg`:
  - state encoding (S_SYNC, S_LEN, S_PAYLOAD, S_CHECK);
  - error codes (ERR_CHK = 2'd1, ERR_LEN = 2'd2, ERR_TO = 2'd3);
  - default `SYNC_BYTE`.
- Sub-module `uart_byte_timer`:
  - parameter `TO_CYC`;
  - inputs `clk`, `res`, `clear`, `run`;
  - output `expire`, a one-cycle pulse at count `TO_CYC−1`.
- The parser computes `TO_CYC` as a localparam and instantiates the timer.

## Test plan
Use `MAX_PAYLOAD` = 8 and `TO_CYC` shortened to 200 for simulation.
1. Bytes 55, AA, 02, 11, 22, CB → `frame_ok` one cycle after CB; `payload[15:0]` = 16'h2211; upper bytes 0; `payload_len` = 2; no `frame_err`.
2. Bytes AA, 00, 00 → `frame_ok`; `payload_len` = 0; `payload` = 0. Then bytes AA, 01, 55, 00 → `frame_err` with code 1; `payload` and `payload_len` still hold frame-1 values.
3. Bytes AA, 09 → `frame_err` with code 2 one cycle after 09; `busy` low afterwards. Then AA, 01, AA, 55 → `frame_ok` with `payload[7:0]` = AA, proving a sync byte is data inside a payload.
4. Bytes AA, 02, 11, then silence → `frame_err` with code 3 exactly 200 cycles after the 11 strobe. A variant with a byte strobed on the expiry cycle → no error, and the frame completes.
5. Bytes AA, 02, 11, then `res` for one cycle, then 22, CB → no pulse at all. A following full frame from scenario 1 → `frame_ok`.
6. Scenario 1 followed immediately by AA, 01, 7F, 80, all with `rx_valid` on consecutive cycles → two `frame_ok` pulses; final `payload[7:0]` = 7F, `payload_len` = 1.
